// File: rtl/frame_uart_tx.sv
// Serialises a wide frame as consecutive 8N1 UART bytes, most significant byte first,
// and pulses send_end for one cycle once the final stop bit has been on the line.
module frame_uart_tx #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD      = 115200,
    parameter int NUM_BYTES = 20
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic [8*NUM_BYTES-1:0]   data_all,
    input  logic                     send_start,
    output logic                     busy,
    output logic                     send_end,
    output logic                     uart_txd
);

    localparam int FW      = 8 * NUM_BYTES;
    localparam int BIT_CYC = CLK_FREQ / BAUD;
    localparam int BAUD_W  = $clog2(BIT_CYC);
    localparam int BYTE_W  = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t              state_q, state_d;
    logic [BAUD_W-1:0]   baud_cnt_q, baud_cnt_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [FW-1:0]       shift_q, shift_d;
    logic                txd_q, txd_d;
    logic                busy_q, busy_d;
    logic                send_end_q, send_end_d;
    logic [7:0]          cur_byte;
    logic                baud_last;

    assign cur_byte  = shift_q[FW-1 -: 8];
    assign baud_last = (baud_cnt_q == BAUD_W'(BIT_CYC - 1));

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= S_IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            send_end_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
            send_end_q <= send_end_d;
        end
    end

    // Frame payload only matters while a frame is in flight, so it carries no reset.
    always_ff @(posedge sys_clk) begin
        shift_q <= shift_d;
    end

    // txd_d is the line level for the cycle after the edge, so the pin stays registered.
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = '0;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        txd_d      = txd_q;
        busy_d     = busy_q;
        send_end_d = 1'b0;

        if (state_q != S_IDLE) begin
            baud_cnt_d = baud_last ? '0 : baud_cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                txd_d = 1'b1;
                if (send_start) begin
                    state_d    = S_START;
                    shift_d    = data_all;
                    byte_cnt_d = '0;
                    bit_cnt_d  = '0;
                    txd_d      = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            S_START: begin
                txd_d = 1'b0;
                if (baud_last) begin
                    state_d   = S_DATA;
                    bit_cnt_d = '0;
                    txd_d     = cur_byte[0];
                end
            end
            S_DATA: begin
                txd_d = cur_byte[bit_cnt_q];
                if (baud_last) begin
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_STOP;
                        txd_d   = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        txd_d     = cur_byte[bit_cnt_q + 3'd1];
                    end
                end
            end
            S_STOP: begin
                txd_d = 1'b1;
                if (baud_last) begin
                    if (byte_cnt_q == BYTE_W'(NUM_BYTES - 1)) begin
                        state_d    = S_IDLE;
                        busy_d     = 1'b0;
                        send_end_d = 1'b1;
                    end else begin
                        state_d    = S_START;
                        byte_cnt_d = byte_cnt_q + 1'b1;
                        shift_d    = shift_q << 8;
                        txd_d      = 1'b0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                txd_d   = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign uart_txd = txd_q;
    assign busy     = busy_q;
    assign send_end = send_end_q;

endmodule

// File: tb/tb_frame_uart_tx.sv
// Bench for frame_uart_tx: compares the line, busy and send_end cycle by cycle against
// an arithmetic frame-timing model and a mid-bit sampling receiver.
module tb_frame_uart_tx;

    localparam int CLK_FREQ  = 1000;
    localparam int BAUD      = 100;
    localparam int NUM_BYTES = 20;
    localparam int FW        = 8 * NUM_BYTES;
    localparam int BIT_CYC   = CLK_FREQ / BAUD;
    localparam int TOT       = NUM_BYTES * 10 * BIT_CYC;

    logic          sys_clk = 1'b0;
    logic          sys_rst;
    logic [FW-1:0] data_all;
    logic          send_start;
    logic          busy;
    logic          send_end;
    logic          uart_txd;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    frame_uart_tx #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .NUM_BYTES (NUM_BYTES)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .data_all   (data_all),
        .send_start (send_start),
        .busy       (busy),
        .send_end   (send_end),
        .uart_txd   (uart_txd)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Expected line level c cycles after acceptance, straight from the frame layout.
    function automatic logic exp_txd(input logic [FW-1:0] d, input int c);
        int bi, by, p;
        if (c < 1 || c > TOT) return 1'b1;
        bi = (c - 1) / BIT_CYC;
        by = bi / 10;
        p  = bi % 10;
        if (p == 0) return 1'b0;
        if (p == 9) return 1'b1;
        return d[FW - 8 * (by + 1) + (p - 1)];
    endfunction

    function automatic logic [FW-1:0] rand_frame();
        logic [FW-1:0] r;
        for (int i = 0; i < FW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Caller is one cycle past a posedge; that cycle becomes cycle 0 of the frame.
    task automatic run_frame(input string tag, input logic [FW-1:0] d, input int inj_cyc,
                             input logic [FW-1:0] inj_d, input bit keep_start,
                             output logic [9:0] first_bits, output int end_t);
        int txd_err, busy_err, end_err, ends, frm_err;
        logic [FW-1:0] dec;
        txd_err = 0; busy_err = 0; end_err = 0; ends = 0; frm_err = 0;
        dec = '0; first_bits = '0; end_t = -1;
        data_all   = d;
        send_start = 1'b1;
        for (int c = 1; c <= TOT + 1; c++) begin
            @(posedge sys_clk); #1;
            if (!keep_start) send_start = 1'b0;
            if (c == inj_cyc) begin
                send_start = 1'b1;
                data_all   = inj_d;
            end
            if (uart_txd !== exp_txd(d, c)) txd_err++;
            if (busy !== (c <= TOT)) busy_err++;
            if (send_end !== (c == TOT + 1)) end_err++;
            if (send_end === 1'b1) begin
                ends++;
                end_t = cyc;
            end
            if (c <= TOT && ((c - 1) % BIT_CYC) == BIT_CYC / 2) begin
                int bi, by, p;
                bi = (c - 1) / BIT_CYC;
                by = bi / 10;
                p  = bi % 10;
                if (bi < 10) first_bits[bi] = uart_txd;
                if (p >= 1 && p <= 8) dec[FW - 8 * (by + 1) + (p - 1)] = uart_txd;
                else if (uart_txd !== (p == 9)) frm_err++;
            end
        end
        check({tag, "_txd_wave"}, FW'(txd_err), '0);
        check({tag, "_busy"}, FW'(busy_err), '0);
        check({tag, "_end_timing"}, FW'(end_err), '0);
        check({tag, "_end_count"}, FW'(ends), FW'(1));
        check({tag, "_framing"}, FW'(frm_err), '0);
        check({tag, "_decoded"}, dec, d);
    endtask

    initial begin
        logic [FW-1:0] d1, d2;
        logic [9:0]    fb;
        int            t1, t2, ends, bad;

        sys_rst = 1'b1; send_start = 1'b0; data_all = '0;
        for (int i = 0; i < 5; i++) begin
            @(posedge sys_clk); #1;
            if (i == 2) begin
                send_start = 1'b1;
                data_all   = rand_frame();
            end
            check("rst_txd", FW'(uart_txd), FW'(1));
            check("rst_busy", FW'(busy), '0);
            check("rst_end", FW'(send_end), '0);
        end
        sys_rst = 1'b0; send_start = 1'b0;
        @(posedge sys_clk); #1;
        check("idle_txd", FW'(uart_txd), FW'(1));
        check("idle_busy", FW'(busy), '0);

        // Single frame, byte i = i+1.
        for (int i = 0; i < NUM_BYTES; i++) d1[FW - 8 * (i + 1) +: 8] = 8'(i + 1);
        run_frame("single", d1, -1, '0, 1'b0, fb, t1);
        check("single_first_byte", FW'(fb), FW'(10'b1000000010));
        repeat (3) @(posedge sys_clk);
        #1;

        // First byte A5: start, 1,0,1,0,0,1,0,1, stop.
        d1 = rand_frame();
        d1[FW-1 -: 8] = 8'hA5;
        run_frame("a5", d1, -1, '0, 1'b0, fb, t1);
        check("a5_bits", FW'(fb), FW'(10'b1101001010));
        @(posedge sys_clk); #1;

        // New request plus new data mid-frame are ignored.
        d1 = rand_frame();
        d2 = rand_frame();
        run_frame("ignore", d1, 500, d2, 1'b0, fb, t1);
        repeat (2) @(posedge sys_clk);
        #1;

        // Back-to-back with send_start held high.
        d1 = rand_frame();
        d2 = rand_frame();
        run_frame("b2b_a", d1, -1, '0, 1'b1, fb, t1);
        run_frame("b2b_b", d2, -1, '0, 1'b0, fb, t2);
        check("b2b_end_gap", FW'(t2 - t1), FW'(TOT + 1));
        @(posedge sys_clk); #1;

        // Reset at cycle 777 aborts the frame.
        d1 = rand_frame();
        data_all = d1; send_start = 1'b1;
        for (int c = 1; c <= 777; c++) begin
            @(posedge sys_clk); #1;
            send_start = 1'b0;
        end
        sys_rst = 1'b1;
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        check("abort_txd", FW'(uart_txd), FW'(1));
        check("abort_busy", FW'(busy), '0);
        check("abort_end", FW'(send_end), '0);
        ends = 0; bad = 0;
        for (int c = 0; c < TOT; c++) begin
            @(posedge sys_clk); #1;
            if (send_end === 1'b1) ends++;
            if (uart_txd !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("abort_no_end", FW'(ends), '0);
        check("abort_idle_line", FW'(bad), '0);
        run_frame("after_abort", rand_frame(), -1, '0, 1'b0, fb, t1);

        // Random frames with random idle gaps.
        for (int k = 0; k < 2; k++) begin
            repeat ($urandom_range(0, 15)) @(posedge sys_clk);
            #1;
            run_frame("random", rand_frame(), -1, '0, 1'b0, fb, t1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
